// File: rtl/pmod_freq_meter.sv
// Multi-channel edge-rate and activity meter with per-channel divided toggle outputs.
// Define FREQ_METER_MINMAX_EN to add per-channel min/max tracking of the latched counts.
module pmod_freq_meter #(
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned GATE_CYCLES = 27_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      I_clk,
    input  logic                      I_rst,
    input  logic                      I_en,
    input  logic [CH_NUM-1:0]         I_sig,
    input  logic [CNT_W-1:0]          I_div_half,
`ifdef FREQ_METER_MINMAX_EN
    input  logic                      I_clr_minmax,
    output logic [CH_NUM*CNT_W-1:0]   O_min,
    output logic [CH_NUM*CNT_W-1:0]   O_max,
`endif
    output logic [CH_NUM*CNT_W-1:0]   O_count,
    output logic [CH_NUM-1:0]         O_ovf,
    output logic                      O_valid,
    output logic [CH_NUM-1:0]         O_toggle
);

    localparam int unsigned     GATE_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // Input synchronisers and registered rising-edge detect
    logic [CH_NUM-1:0][SYNC_STAGES-1:0] sync_q;
    logic [CH_NUM-1:0]                  sync_last;
    logic [CH_NUM-1:0]                  prev_q;
    logic [CH_NUM-1:0]                  pulse_q;

    always_comb begin
        sync_last = '0;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            sync_last[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            sync_q  <= '0;
            prev_q  <= '0;
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < int'(CH_NUM); i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], I_sig[i]};
            end
            prev_q  <= sync_last;
            pulse_q <= sync_last & ~prev_q;
        end
    end

    // Gate window
    logic [GATE_W-1:0] gate_q, gate_d;
    logic              tc;
    logic              valid_q, valid_d;

    always_comb begin
        tc      = I_en && (gate_q == GATE_LAST);
        valid_d = tc;
        if (!I_en || tc) begin
            gate_d = '0;
        end else begin
            gate_d = gate_q + 1'b1;
        end
    end

    // Per-channel edge counters, latched results and dividers
    logic [CH_NUM-1:0][CNT_W-1:0] edge_q, edge_d;
    logic [CH_NUM-1:0]            win_ovf_q, win_ovf_d;
    logic [CH_NUM-1:0][CNT_W-1:0] inc_cnt;
    logic [CH_NUM-1:0]            inc_ovf;
    logic [CH_NUM-1:0][CNT_W-1:0] count_q, count_d;
    logic [CH_NUM-1:0]            ovf_q, ovf_d;
    logic [CH_NUM-1:0][CNT_W-1:0] div_q, div_d;
    logic [CH_NUM-1:0]            tog_q, tog_d;

    always_comb begin
        edge_d    = edge_q;
        win_ovf_d = win_ovf_q;
        inc_cnt   = edge_q;
        inc_ovf   = win_ovf_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        div_d     = div_q;
        tog_d     = tog_q;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            // Saturating increment; this value is also what gets latched at TC
            if (pulse_q[i]) begin
                if (edge_q[i] == CNT_MAX) begin
                    inc_ovf[i] = 1'b1;
                end else begin
                    inc_cnt[i] = edge_q[i] + 1'b1;
                end
            end

            if (!I_en || tc) begin
                edge_d[i]    = '0;
                win_ovf_d[i] = 1'b0;
            end else begin
                edge_d[i]    = inc_cnt[i];
                win_ovf_d[i] = inc_ovf[i];
            end

            if (tc) begin
                count_d[i] = inc_cnt[i];
                ovf_d[i]   = inc_ovf[i];
            end

            // Divider ignores the gate and I_en; >= covers a shrunk I_div_half
            if (I_div_half == '0) begin
                div_d[i] = '0;
            end else if (pulse_q[i]) begin
                if (div_q[i] >= I_div_half - 1'b1) begin
                    div_d[i] = '0;
                    tog_d[i] = ~tog_q[i];
                end else begin
                    div_d[i] = div_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            gate_q    <= '0;
            valid_q   <= 1'b0;
            edge_q    <= '0;
            win_ovf_q <= '0;
            count_q   <= '0;
            ovf_q     <= '0;
            div_q     <= '0;
            tog_q     <= '0;
        end else begin
            gate_q    <= gate_d;
            valid_q   <= valid_d;
            edge_q    <= edge_d;
            win_ovf_q <= win_ovf_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            tog_q     <= tog_d;
        end
    end

    assign O_count  = count_q;
    assign O_ovf    = ovf_q;
    assign O_valid  = valid_q;
    assign O_toggle = tog_q;

`ifdef FREQ_METER_MINMAX_EN
    logic [CH_NUM-1:0][CNT_W-1:0] min_q, min_d;
    logic [CH_NUM-1:0][CNT_W-1:0] max_q, max_d;

    // Clear wins over folding in a count latched in the same cycle
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        for (int i = 0; i < int'(CH_NUM); i++) begin
            if (I_clr_minmax) begin
                min_d[i] = CNT_MAX;
                max_d[i] = '0;
            end else if (tc) begin
                if (inc_cnt[i] < min_q[i]) min_d[i] = inc_cnt[i];
                if (inc_cnt[i] > max_q[i]) max_d[i] = inc_cnt[i];
            end
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            min_q <= {CH_NUM{CNT_MAX}};
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign O_min = min_q;
    assign O_max = max_q;
`endif

endmodule

// File: tb/tb_pmod_freq_meter.sv
// Directed bench for pmod_freq_meter: 2 channels, 4-bit counters, 100-cycle gate window.
module tb_pmod_freq_meter;

    localparam int CH   = 2;
    localparam int CW   = 4;
    localparam int GATE = 100;

    logic          clk;
    logic          rst;
    logic          en;
    logic [CH-1:0] sig_w;
    logic [CW-1:0] div_half;
    logic [CH*CW-1:0] count;
    logic [CH-1:0] ovf;
    logic          valid;
    logic [CH-1:0] toggle;
`ifdef FREQ_METER_MINMAX_EN
    logic          clr_mm;
    logic [CH*CW-1:0] omin;
    logic [CH*CW-1:0] omax;
`endif

    pmod_freq_meter #(
        .CH_NUM(CH), .CNT_W(CW), .GATE_CYCLES(GATE), .SYNC_STAGES(2)
    ) dut (
        .I_clk(clk), .I_rst(rst), .I_en(en), .I_sig(sig_w), .I_div_half(div_half),
`ifdef FREQ_METER_MINMAX_EN
        .I_clr_minmax(clr_mm), .O_min(omin), .O_max(omax),
`endif
        .O_count(count), .O_ovf(ovf), .O_valid(valid), .O_toggle(toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Square-wave generators; period 0 means "drive hold[c]"
    int          per [CH];
    int          ph  [CH];
    logic [CH-1:0] gen;
    logic [CH-1:0] hold;

    always_comb begin
        for (int c = 0; c < CH; c++) sig_w[c] = (per[c] == 0) ? hold[c] : gen[c];
    end

    initial begin
        gen = '0;
        for (int c = 0; c < CH; c++) begin per[c] = 0; ph[c] = 0; end
        forever begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if (per[c] != 0) begin
                    ph[c]  = (ph[c] + 1 >= per[c]) ? 0 : ph[c] + 1;
                    gen[c] = (ph[c] < per[c] / 2);
                end else begin
                    ph[c] = 0;
                end
            end
        end
    end

    int npass  = 0;
    int ntotal = 0;

    task automatic check(input string name, input int act, input int exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Returns negedges elapsed until O_valid is seen (bounded)
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < 400);
        if (!valid) check("valid_timeout", 0, 1);
    endtask

    task automatic wait_toggle(input logic t0, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (toggle[0] == t0 && n < 400);
        if (toggle[0] == t0) check("toggle_timeout", 0, 1);
    endtask

    typedef struct {
        int per0;
        int per1;
        int exp_c0;
        int exp_c1;
        int exp_ovf;
    } vec_t;

    vec_t vecs [6];
    int   n;
    int   held;
    int   nvalid;
    logic t0;

    initial begin
        vecs[0] = '{per0: 10, per1: 0,  exp_c0: 10, exp_c1: 0,  exp_ovf: 0};
        vecs[1] = '{per0: 4,  per1: 0,  exp_c0: 15, exp_c1: 0,  exp_ovf: 1};
        vecs[2] = '{per0: 0,  per1: 0,  exp_c0: 0,  exp_c1: 0,  exp_ovf: 0};
        vecs[3] = '{per0: 20, per1: 10, exp_c0: 5,  exp_c1: 10, exp_ovf: 0};
        vecs[4] = '{per0: 10, per1: 4,  exp_c0: 10, exp_c1: 15, exp_ovf: 2};
        vecs[5] = '{per0: 5,  per1: 50, exp_c0: 15, exp_c1: 2,  exp_ovf: 1};

        rst = 1'b1; en = 1'b0; div_half = '0; hold = '0;
`ifdef FREQ_METER_MINMAX_EN
        clr_mm = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_count",  int'(count),  0);
        check("rst_ovf",    int'(ovf),    0);
        check("rst_valid",  int'(valid),  0);
        check("rst_toggle", int'(toggle), 0);
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;

        // Table: discard the mixed window, check the following full one
        for (int v = 0; v < 6; v++) begin
            per[0] = vecs[v].per0;
            per[1] = vecs[v].per1;
            wait_valid(n);
            wait_valid(n);
            check($sformatf("v%0d_spacing", v), n, GATE);
            check($sformatf("v%0d_count0", v), int'(count[0*CW +: CW]), vecs[v].exp_c0);
            check($sformatf("v%0d_count1", v), int'(count[1*CW +: CW]), vecs[v].exp_c1);
            check($sformatf("v%0d_ovf", v), int'(ovf), vecs[v].exp_ovf);
        end

        // Divider: 5 pulses per half-period at period 10 -> 50 cycles per toggle
        per[0] = 10; per[1] = 0; hold = '0;
        div_half = 4'd5;
        t0 = toggle[0];
        wait_toggle(t0, n);
        t0 = toggle[0];
        wait_toggle(t0, n);
        check("div_half_period", n, 50);
        div_half = '0;
        t0 = toggle[0];
        repeat (200) @(negedge clk);
        check("div_frozen", int'(toggle[0]), int'(t0));

        // Enable drop at gate count 50 for 20 cycles
        wait_valid(n);
        repeat (50) @(negedge clk);
        en = 1'b0;
        held = int'(count);
        nvalid = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        check("en_off_no_valid", nvalid, 0);
        check("en_off_count_held", int'(count), held);
        en = 1'b1;
        wait_valid(n);
        check("reenable_spacing", n, GATE);
        check("reenable_count0", int'(count[0*CW +: CW]), 10);

        // Edge pulse landing in the TC cycle belongs to the closing window
        wait_valid(n);
        repeat (96) @(negedge clk);
        hold[1] = 1'b1;
        wait_valid(n);
        check("tc_edge_spacing", n, 4);
        check("tc_edge_count1", int'(count[1*CW +: CW]), 1);
        wait_valid(n);
        check("after_tc_count1", int'(count[1*CW +: CW]), 0);
        hold[1] = 1'b0;

`ifdef FREQ_METER_MINMAX_EN
        clr_mm = 1'b1;
        @(negedge clk);
        clr_mm = 1'b0;
        per[0] = 10;
        wait_valid(n);
        wait_valid(n);
        per[0] = 20;
        wait_valid(n);
        wait_valid(n);
        check("mm_min0", int'(omin[0*CW +: CW]), 5);
        check("mm_max0", int'(omax[0*CW +: CW]), 10);
        repeat (99) @(negedge clk);
        clr_mm = 1'b1;
        @(negedge clk);
        clr_mm = 1'b0;
        check("mm_clr_tc_valid", int'(valid), 1);
        check("mm_clr_min0", int'(omin[0*CW +: CW]), 15);
        check("mm_clr_max0", int'(omax[0*CW +: CW]), 0);
`endif

        // Asynchronous reset mid-window, applied between clock edges
        per[0] = 10;
        div_half = 4'd1;
        wait_valid(n);
        repeat (30) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("arst_count",  int'(count),  0);
        check("arst_ovf",    int'(ovf),    0);
        check("arst_valid",  int'(valid),  0);
        check("arst_toggle", int'(toggle), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
